// File: rtl/MIPS_pkg.sv
// MIPS_pkg: types and constants shared between the instruction-memory loader and the core.
package MIPS_pkg;

    // Instruction word width used by the core and by the loader's data path.
    localparam int unsigned InstrWidth = 16;

    // Loader control states.
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StDone,
        StError
    } loader_state_e;

    // Limit a requested word count to the memory depth.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams a program from a valid/ready source into instruction memory while
// holding the MIPS core in reset, then releases the core.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailer word after the
// program such that the modulo-2^DATA_W sum of all loaded words plus the trailer is zero.
module imem_loader
    import MIPS_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = InstrWidth
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_wdata_o,
    output logic              core_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              chk_err_o
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    loader_state_e     state_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              in_ready_q;
    logic              we_q;
    logic              core_rst_q;
    logic              busy_q;
    logic              done_q;

    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W:0]   cnt_inc;
    logic              accept;
    logic              last_word;
    logic              restart;
    logic              from_idle;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_nxt;
    logic              chk_err_q;
`endif

    assign len_clamped = (ADDR_W+1)'(clamp_len(32'(len_i), DEPTH));
    assign cnt_inc     = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    assign accept      = in_valid_i & in_ready_q;
    assign last_word   = (cnt_inc == len_q);
    assign from_idle   = (state_q == StIdle);
    // A start is honoured only when no load or trailer check is in flight.
    assign restart     = start_i &&
                         ((state_q == StIdle) || (state_q == StDone) || (state_q == StError));

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign sum_nxt = sum_q + in_data_i;
`endif

    // Control FSM; every output is registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            if (restart) begin
                cnt_q <= '0;
                len_q <= len_clamped;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q     <= '0;
                chk_err_q <= 1'b0;
`endif
                if (len_clamped == '0) begin
                    state_q    <= StDone;
                    // From idle the core was never released, so it can go at once; a
                    // restart from a finished load pulses the core reset for one cycle.
                    done_q     <= from_idle;
                    core_rst_q <= ~from_idle;
                end else begin
                    state_q    <= StLoad;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b1;
                    done_q     <= 1'b0;
                    core_rst_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    StLoad: begin
                        if (accept) begin
                            we_q    <= 1'b1;
                            addr_q  <= cnt_q[ADDR_W-1:0];
                            wdata_q <= in_data_i;
                            cnt_q   <= cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            sum_q   <= sum_nxt;
                            if (last_word) begin
                                state_q <= StCheck;
                            end
`else
                            if (last_word) begin
                                // Core stays held this cycle: the final write is still going out.
                                state_q    <= StDone;
                                in_ready_q <= 1'b0;
                                busy_q     <= 1'b0;
                            end
`endif
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    StCheck: begin
                        // The trailer is consumed but never written to memory.
                        if (accept) begin
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            if (sum_nxt == '0) begin
                                state_q    <= StDone;
                                done_q     <= 1'b1;
                                core_rst_q <= 1'b0;
                            end else begin
                                state_q   <= StError;
                                chk_err_q <= 1'b1;
                            end
                        end
                    end
`endif
                    StDone: begin
                        done_q     <= 1'b1;
                        core_rst_q <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign in_ready_o   = in_ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign core_rst_o   = core_rst_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign chk_err_o    = chk_err_q;
`else
    assign chk_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader. The source is a queue of
// words; the expected memory image is simply the first min(len, DEPTH) words of that queue.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 16;
    localparam int          DEPTH  = 1 << ADDR_W;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic [ADDR_W:0]   len_i;
    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [DATA_W-1:0] imem_wdata_o;
    logic              core_rst_o;
    logic              busy_o;
    logic              done_o;
    logic              chk_err_o;

    imem_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .len_i       (len_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .imem_we_o   (imem_we_o),
        .imem_addr_o (imem_addr_o),
        .imem_wdata_o(imem_wdata_o),
        .core_rst_o  (core_rst_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .chk_err_o   (chk_err_o)
    );

    always #5 clk_i = ~clk_i;

    int total;
    int bad;

    // Source words and what the transfer observed.
    logic [DATA_W-1:0] stream   [$];
    int                wr_addr  [$];
    logic [DATA_W-1:0] wr_data  [$];
    int                wr_cyc   [$];
    logic              wr_rst   [$];
    int                acc_cyc  [$];
    logic              rdy_hist [$];
    int                first_done;
    int                first_rel;
    bit                timed_out;

`ifdef IMEM_LOADER_CHECKSUM_EN
    function automatic logic [DATA_W-1:0] trailer_for(input int n);
        logic [DATA_W-1:0] s;
        s = '0;
        for (int i = 0; i < n; i++) s = s + stream[i];
        return -s;
    endfunction
`endif

    // Drive one load from the stream queue and record what the DUT did (no checking here).
    task automatic run_transfer(input int len, input int gap, input bit rand_gap,
                                input int glitch_at);
        int sent;
        int hold;
        int settle;
        sent = 0; hold = 0; settle = 0;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); wr_rst.delete();
        acc_cyc.delete(); rdy_hist.delete();
        first_done = -1; first_rel = -1; timed_out = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_i);
            rdy_hist.push_back(in_ready_o);
            if (c > 0) begin
                if (imem_we_o) begin
                    wr_addr.push_back(int'(imem_addr_o));
                    wr_data.push_back(imem_wdata_o);
                    wr_cyc.push_back(c);
                    wr_rst.push_back(core_rst_o);
                end
                if (done_o && first_done < 0) first_done = c;
                if (!core_rst_o && first_rel < 0) first_rel = c;
                if (first_done >= 0 || chk_err_o) settle++;
            end
            if (settle > 3) begin
                timed_out = 1'b0;
                break;
            end
            start_i = (c == 0) || (c == glitch_at);
            len_i   = (c == 0) ? len[ADDR_W:0] : (ADDR_W+1)'(1);
            if (hold > 0) begin
                hold--;
                in_valid_i = 1'b0;
            end else if (sent < stream.size()) begin
                in_valid_i = 1'b1;
                in_data_i  = stream[sent];
            end else begin
                in_valid_i = 1'b0;
            end
            if (in_valid_i && in_ready_o) begin
                acc_cyc.push_back(c);
                sent++;
                hold = rand_gap ? int'($urandom_range(gap, 0)) : gap;
            end
        end
        start_i = 1'b0;
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        total++;
        if ({core_rst_o, imem_we_o, in_ready_o, busy_o, done_o, chk_err_o} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_outputs: got rst/we/rdy/busy/done/err=%b want 100000",
                     {core_rst_o, imem_we_o, in_ready_o, busy_o, done_o, chk_err_o});
        end
        rst_ni = 1'b1;
        in_valid_i = 1'b1;
        in_data_i = 16'hBEEF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            total++;
            if ({core_rst_o, imem_we_o, in_ready_o, busy_o} !== 4'b1000) begin
                bad++;
                $display("FAIL idle_hold[%0d]: got rst/we/rdy/busy=%b want 1000", c,
                         {core_rst_o, imem_we_o, in_ready_o, busy_o});
            end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        stream = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(trailer_for(4));
`endif
        run_transfer(4, 0, 1'b0, -1);
        total++;
        if (timed_out) begin bad++; $display("FAIL b2b_timeout: got no done, want done"); end
        total++;
        if (wr_addr.size() != 4) begin
            bad++; $display("FAIL b2b_count: got %0d writes want 4", wr_addr.size());
        end
        for (int k = 0; k < wr_addr.size() && k < 4; k++) begin
            total++;
            if (wr_addr[k] != k || wr_data[k] !== stream[k]) begin
                bad++;
                $display("FAIL b2b_write[%0d]: got addr=%0d data=%h want addr=%0d data=%h",
                         k, wr_addr[k], wr_data[k], k, stream[k]);
            end
            total++;
            if (wr_cyc[k] != acc_cyc[k] + 1 || acc_cyc[k] != acc_cyc[0] + k) begin
                bad++;
                $display("FAIL b2b_timing[%0d]: got wr_cyc=%0d acc_cyc=%0d want %0d/%0d", k,
                         wr_cyc[k], acc_cyc[k], acc_cyc[k] + 1, acc_cyc[0] + k);
            end
            total++;
            if (wr_rst[k] !== 1'b1) begin
                bad++; $display("FAIL b2b_core_held[%0d]: got core_rst=%b want 1", k, wr_rst[k]);
            end
        end
        if (wr_cyc.size() == 4) begin
            total++;
            if (first_rel <= wr_cyc[3]) begin
                bad++;
                $display("FAIL b2b_release: got core_rst low at %0d want after %0d",
                         first_rel, wr_cyc[3]);
            end
`ifndef IMEM_LOADER_CHECKSUM_EN
            total++;
            if (rdy_hist[acc_cyc[3] + 1] !== 1'b0) begin
                bad++; $display("FAIL b2b_ready_drop: got in_ready=1 after last word want 0");
            end
`endif
        end
        total++;
        if ({done_o, core_rst_o, busy_o, in_ready_o} !== 4'b1000) begin
            bad++;
            $display("FAIL b2b_done: got done/rst/busy/rdy=%b want 1000",
                     {done_o, core_rst_o, busy_o, in_ready_o});
        end
    endtask

    task automatic test_gaps();
        stream.delete();
        for (int i = 0; i < 3; i++) stream.push_back(DATA_W'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(trailer_for(3));
`endif
        run_transfer(3, 2, 1'b0, -1);
        total++;
        if (timed_out || wr_addr.size() != 3) begin
            bad++;
            $display("FAIL gap_count: got %0d writes timeout=%0d want 3 writes",
                     wr_addr.size(), timed_out);
        end
        for (int k = 0; k < wr_addr.size() && k < 3; k++) begin
            total++;
            if (wr_addr[k] != k || wr_data[k] !== stream[k] || wr_cyc[k] != acc_cyc[k] + 1) begin
                bad++;
                $display("FAIL gap_write[%0d]: got addr=%0d data=%h cyc=%0d want %0d %h %0d",
                         k, wr_addr[k], wr_data[k], wr_cyc[k], k, stream[k], acc_cyc[k] + 1);
            end
            if (k > 0) begin
                total++;
                if (wr_cyc[k] - wr_cyc[k-1] != 3) begin
                    bad++;
                    $display("FAIL gap_spacing[%0d]: got %0d cycles want 3", k,
                             wr_cyc[k] - wr_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_len0();
        bit seen_done;
        bit seen_we;
        @(negedge clk_i); rst_ni = 1'b0;
        @(negedge clk_i); rst_ni = 1'b1;
        @(negedge clk_i); start_i = 1'b1; len_i = '0;
        @(negedge clk_i); start_i = 1'b0;
        total++;
        if ({done_o, core_rst_o, imem_we_o, busy_o, in_ready_o} !== 5'b10000) begin
            bad++;
            $display("FAIL len0_done: got done/rst/we/busy/rdy=%b want 10000",
                     {done_o, core_rst_o, imem_we_o, busy_o, in_ready_o});
        end
        start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        total++;
        if ({core_rst_o, done_o, imem_we_o} !== 3'b100) begin
            bad++;
            $display("FAIL len0_restart: got rst/done/we=%b want 100",
                     {core_rst_o, done_o, imem_we_o});
        end
        seen_done = 1'b0; seen_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (imem_we_o) seen_we = 1'b1;
            if (done_o && !core_rst_o) seen_done = 1'b1;
        end
        total++;
        if (!seen_done || seen_we) begin
            bad++;
            $display("FAIL len0_redone: got done_seen=%0d we_seen=%0d want 1 0",
                     seen_done, seen_we);
        end
    endtask

    task automatic test_clamp();
        stream.delete();
        for (int i = 0; i < DEPTH; i++) stream.push_back(DATA_W'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(trailer_for(DEPTH));
`endif
        for (int i = 0; i < 5; i++) stream.push_back(DATA_W'($urandom));
        run_transfer(DEPTH + 5, 0, 1'b0, -1);
        total++;
        if (timed_out || wr_addr.size() != DEPTH) begin
            bad++;
            $display("FAIL clamp_count: got %0d writes timeout=%0d want %0d",
                     wr_addr.size(), timed_out, DEPTH);
        end
        for (int k = 0; k < wr_addr.size() && k < DEPTH; k++) begin
            total++;
            if (wr_addr[k] != k || wr_data[k] !== stream[k] || wr_cyc[k] != acc_cyc[k] + 1) begin
                bad++;
                $display("FAIL clamp_write[%0d]: got addr=%0d data=%h want addr=%0d data=%h",
                         k, wr_addr[k], wr_data[k], k, stream[k]);
            end
        end
        total++;
        if (done_o !== 1'b1 || core_rst_o !== 1'b0) begin
            bad++; $display("FAIL clamp_done: got done=%b rst=%b want 1 0", done_o, core_rst_o);
        end
    endtask

    // Random lengths, gaps and data; a stray start mid-load must change nothing.
    task automatic test_random();
        int n;
        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(DEPTH, 6));
            stream.delete();
            for (int i = 0; i < n; i++) stream.push_back(DATA_W'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
            stream.push_back(trailer_for(n));
`endif
            run_transfer(n, int'($urandom_range(3, 0)), 1'b1, 3);
            total++;
            if (timed_out || wr_addr.size() != n || first_done < 0) begin
                bad++;
                $display("FAIL rnd%0d_count: got %0d writes done_at=%0d want %0d writes",
                         it, wr_addr.size(), first_done, n);
            end
            for (int k = 0; k < wr_addr.size() && k < n; k++) begin
                total++;
                if (wr_addr[k] != k || wr_data[k] !== stream[k] || wr_cyc[k] != acc_cyc[k] + 1
                    || wr_rst[k] !== 1'b1) begin
                    bad++;
                    $display("FAIL rnd%0d_write[%0d]: got addr=%0d data=%h want addr=%0d %h",
                             it, k, wr_addr[k], wr_data[k], k, stream[k]);
                end
            end
            if (wr_cyc.size() == n) begin
                total++;
                if (first_rel <= wr_cyc[n-1]) begin
                    bad++;
                    $display("FAIL rnd%0d_release: got core_rst low at %0d want after %0d",
                             it, first_rel, wr_cyc[n-1]);
                end
            end
        end
    endtask

    task automatic test_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream = '{16'h0001, 16'h0002, 16'hFFFD};
        run_transfer(2, 0, 1'b0, -1);
        total++;
        if ({done_o, core_rst_o, chk_err_o} !== 3'b100 || wr_addr.size() != 2) begin
            bad++;
            $display("FAIL chk_good: got done/rst/err=%b writes=%0d want 100 and 2",
                     {done_o, core_rst_o, chk_err_o}, wr_addr.size());
        end
        stream = '{16'h0001, 16'h0002, 16'h0000};
        run_transfer(2, 0, 1'b0, -1);
        total++;
        if ({done_o, core_rst_o, chk_err_o, busy_o} !== 4'b0110 || wr_addr.size() != 2) begin
            bad++;
            $display("FAIL chk_bad: got done/rst/err/busy=%b writes=%0d want 0110 and 2",
                     {done_o, core_rst_o, chk_err_o, busy_o}, wr_addr.size());
        end
`else
        stream = '{16'h0001, 16'h0002};
        run_transfer(2, 0, 1'b0, -1);
        total++;
        if ({done_o, core_rst_o, chk_err_o} !== 3'b100 || wr_addr.size() != 2) begin
            bad++;
            $display("FAIL chk_off: got done/rst/err=%b writes=%0d want 100 and 2",
                     {done_o, core_rst_o, chk_err_o}, wr_addr.size());
        end
`endif
    endtask

    // Asynchronous reset after two of five words: no further writes, outputs at reset values.
    task automatic test_mid_reset();
        int sent;
        int nwr;
        stream.delete();
        for (int i = 0; i < 5; i++) stream.push_back(DATA_W'($urandom));
        sent = 0; nwr = 0;
        @(negedge clk_i);
        start_i = 1'b1; len_i = (ADDR_W+1)'(5);
        in_valid_i = 1'b1; in_data_i = stream[0];
        for (int c = 0; c < 50 && sent < 2; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (imem_we_o) nwr++;
            in_data_i = stream[sent];
            if (in_ready_o) sent++;
        end
        @(negedge clk_i);
        if (imem_we_o) nwr++;
        in_data_i = stream[sent];
        total++;
        if (nwr != 2) begin bad++; $display("FAIL mid_pre_writes: got %0d want 2", nwr); end
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if ({core_rst_o, imem_we_o, in_ready_o, busy_o, done_o, chk_err_o} !== 6'b100000) begin
            bad++;
            $display("FAIL mid_async: got rst/we/rdy/busy/done/err=%b want 100000",
                     {core_rst_o, imem_we_o, in_ready_o, busy_o, done_o, chk_err_o});
        end
        nwr = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (imem_we_o) nwr++;
        end
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (imem_we_o) nwr++;
            total++;
            if ({core_rst_o, in_ready_o, busy_o, done_o} !== 4'b1000) begin
                bad++;
                $display("FAIL mid_after[%0d]: got rst/rdy/busy/done=%b want 1000", c,
                         {core_rst_o, in_ready_o, busy_o, done_o});
            end
        end
        in_valid_i = 1'b0;
        total++;
        if (nwr != 0) begin bad++; $display("FAIL mid_no_writes: got %0d want 0", nwr); end
    endtask

    initial begin
        rst_ni = 1'b0;
        start_i = 1'b0;
        len_i = '0;
        in_valid_i = 1'b0;
        in_data_i = '0;
        total = 0;
        bad = 0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_len0();
        test_clamp();
        test_random();
        test_checksum();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width (DEPTH = 2**ADDR_W words).
REQ-002 Parameter DATA_W, default 16, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  single-cycle request to begin a program load.
REQ-006 len  input  ADDR_W+1  number of instruction words to load, sampled with start.
REQ-007 in_valid  input  1  source presents a word on in_data.
REQ-008 in_data  input  DATA_W  instruction word from source.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 imem_we  output  1  write strobe to instruction memory.
REQ-011 imem_addr  output  ADDR_W  write address.
REQ-012 imem_wdata  output  DATA_W  write data.
REQ-013 core_rst  output  1  active-high reset to the MIPS core; core held while 1.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  program loaded, core released.
REQ-016 chk_err  output  1  checksum mismatch flag.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, CHECK, DONE, ERROR.
REQ-018 IDLE: core_rst=1, in_ready=0; start with len>0 -> LOAD; start with len=0 -> DONE, no writes.
REQ-019 len > DEPTH SHALL be clamped to DEPTH.
REQ-020 LOAD: in_ready=1, busy=1; a word is accepted when in_valid and in_ready are both high.
REQ-021 Accepted word k (0-based) SHALL appear as imem_we=1, imem_addr=k, imem_wdata=word exactly one cycle after acceptance; imem_we=0 otherwise.
REQ-022 Word address counter SHALL start at 0 on every start and SHALL NOT wrap; at DEPTH words the load ends.
REQ-023 After the last word is accepted, LOAD -> CHECK (checksum enabled) or DONE (disabled) on the next edge; in_ready deasserts in that same next cycle.
REQ-024 DONE: core_rst=0, done=1, busy=0, in_ready=0; core_rst falls no earlier than the cycle after the final imem_we.
REQ-025 start in DONE or ERROR SHALL reassert core_rst next cycle and begin a new load (LOAD or DONE per len); start in LOAD or CHECK SHALL be ignored.
REQ-026 in_valid while in_ready=0 SHALL be ignored (word not consumed).

Reset
REQ-027 On rst low: state=IDLE, counter=0, checksum=0, core_rst=1, imem_we=0, in_ready=0, busy=0, done=0, chk_err=0, immediately and asynchronously.
REQ-028 Reset mid-load SHALL abort without further writes; already-written words remain in memory.

Configuration
REQ-029 Macro IMEM_LOADER_CHECKSUM_EN: when defined, a DATA_W-bit modulo-2^DATA_W running sum of loaded words is kept; CHECK accepts one trailer word (in_ready=1, not written to memory); sum+trailer==0 -> DONE, else ERROR (core_rst=1, chk_err=1, busy=0) until start or reset.
REQ-030 Without IMEM_LOADER_CHECKSUM_EN: CHECK and ERROR are unreachable/omitted, chk_err tied 0, no trailer expected.

Structure
REQ-031 MIPS_pkg SHALL hold the loader state enum type and the instruction width constant shared with the core.
REQ-032 Single module; no sub-module required.

Verification
REQ-033 Reset, start len=4, words 0x1111,0x2222,0x3333,0x4444 back-to-back -> writes addr 0..3 one cycle after each accept, done=1, core_rst=0.
REQ-034 len=3 with in_valid gaps of 2 cycles -> exactly 3 writes, addresses contiguous, no write during gaps.
REQ-035 start len=0 -> DONE next cycle, imem_we never asserted.
REQ-036 len=DEPTH+5 -> exactly DEPTH writes, last addr=DEPTH-1, no wrap to 0.
REQ-037 Checksum on: words 0x0001,0x0002 then trailer 0xFFFD -> DONE; trailer 0x0000 -> ERROR, chk_err=1, core_rst=1.
REQ-038 rst low after 2 of 5 words -> all outputs at reset values asynchronously, core_rst=1, no further writes.
